// File: rtl/camera_window_capture_if.sv
// Bundle for the window capture block: sensor pins, window configuration and
// the cropped pixel stream with its frame markers and status.
interface camera_window_capture_if #(
  parameter int DATA_WIDTH    = 10,
  parameter int RAW_COL_BITS  = 10,
  parameter int RAW_LINE_BITS = 9,
  parameter int COL_BITS      = 10,
  parameter int LINE_BITS     = 9,
  parameter int FCNT_BITS     = 8
);
  logic                     LINE_VALID;
  logic                     FRAME_VALID;
  logic [DATA_WIDTH-1:0]    DATA_IN;
  logic [RAW_COL_BITS-1:0]  WIN_X0;
  logic [RAW_LINE_BITS-1:0] WIN_Y0;
  logic [RAW_COL_BITS-1:0]  WIN_W;
  logic [RAW_LINE_BITS-1:0] WIN_H;
  logic                     DECIM;
  logic [DATA_WIDTH-1:0]    DATA_OUT;
  logic [COL_BITS-1:0]      CURRENT_COLUMN;
  logic [LINE_BITS-1:0]     CURRENT_LINE;
  logic                     PIXEL_VALID;
  logic                     FRAME_START;
  logic                     FRAME_END;
  logic [FCNT_BITS-1:0]     FRAME_COUNT;
  logic                     LINE_ERROR;

  // Sensor/configuration side drives the pixel stream and window settings
  modport master (
    output LINE_VALID, FRAME_VALID, DATA_IN, WIN_X0, WIN_Y0, WIN_W, WIN_H, DECIM,
    input  DATA_OUT, CURRENT_COLUMN, CURRENT_LINE, PIXEL_VALID,
           FRAME_START, FRAME_END, FRAME_COUNT, LINE_ERROR
  );

  // Capture block consumes the stream and produces the windowed output
  modport slave (
    input  LINE_VALID, FRAME_VALID, DATA_IN, WIN_X0, WIN_Y0, WIN_W, WIN_H, DECIM,
    output DATA_OUT, CURRENT_COLUMN, CURRENT_LINE, PIXEL_VALID,
           FRAME_START, FRAME_END, FRAME_COUNT, LINE_ERROR
  );
endinterface

// File: rtl/camera_window_capture.sv
// Parallel-sensor front end: frames the raw pixel stream, crops a window that
// is latched at frame start, optionally decimates 2x2, and reports frame
// markers, a completed-frame counter and a per-frame line-length error flag.
module camera_window_capture #(
  parameter int DATA_WIDTH    = 10,
  parameter int RAW_COL_BITS  = 10,
  parameter int RAW_LINE_BITS = 9,
  parameter int COL_BITS      = 10,
  parameter int LINE_BITS     = 9,
  parameter int FCNT_BITS     = 8
) (
  input logic                    PIXCLK,
  input logic                    RESET_N,
  camera_window_capture_if.slave bus
);
  // One extra bit so that X0+W and Y0+H never wrap
  localparam int CW = RAW_COL_BITS + 1;
  localparam int LW = RAW_LINE_BITS + 1;

  typedef enum logic [1:0] {WAIT_IDLE = 2'd0, IDLE = 2'd1, ACTIVE = 2'd2} state_t;
  state_t state_reg, state_next;

  logic [RAW_COL_BITS-1:0]  x0_reg, w_reg, raw_col_reg, first_len_reg;
  logic [RAW_LINE_BITS-1:0] y0_reg, h_reg, raw_line_reg;
  logic                     decim_reg, lv_prev_reg, have_len_reg, line_error_reg;
  logic                     frame_start_reg, frame_end_reg, pixel_valid_reg;
  logic [FCNT_BITS-1:0]     frame_count_reg;
  logic [DATA_WIDTH-1:0]    data_reg;
  logic [COL_BITS-1:0]      column_reg;
  logic [LINE_BITS-1:0]     line_reg;

  logic          frame_begin, frame_finish, in_frame, line_end, accept;
  logic          in_cols, in_lines;
  logic [CW-1:0] col_ext, x0_ext, col_lim, rc;
  logic [LW-1:0] line_ext, y0_ext, line_lim, rl;

  // State register; reset parks in WAIT_IDLE so a frame already running is dropped
  always_ff @(posedge PIXCLK) begin
    if (!RESET_N) state_reg <= WAIT_IDLE;
    else          state_reg <= state_next;
  end

  // Next-state decode from FRAME_VALID only
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      WAIT_IDLE: if (!bus.FRAME_VALID) state_next = IDLE;
      IDLE:      if (bus.FRAME_VALID)  state_next = ACTIVE;
      ACTIVE:    if (!bus.FRAME_VALID) state_next = IDLE;
      default:   state_next = WAIT_IDLE;
    endcase
  end

  // Per-state control strobes for the datapath
  always_comb begin
    frame_begin  = (state_reg == IDLE) && bus.FRAME_VALID;
    frame_finish = (state_reg == ACTIVE) && !bus.FRAME_VALID;
    in_frame     = (state_reg == ACTIVE) && bus.FRAME_VALID;
    line_end     = in_frame && lv_prev_reg && !bus.LINE_VALID;
  end

  // Window test on the current raw position against the latched window
  always_comb begin
    col_ext  = {1'b0, raw_col_reg};
    x0_ext   = {1'b0, x0_reg};
    col_lim  = x0_ext + {1'b0, w_reg};
    rc       = col_ext - x0_ext;
    line_ext = {1'b0, raw_line_reg};
    y0_ext   = {1'b0, y0_reg};
    line_lim = y0_ext + {1'b0, h_reg};
    rl       = line_ext - y0_ext;
    in_cols  = (col_ext >= x0_ext) && (col_ext < col_lim);
    in_lines = (line_ext >= y0_ext) && (line_ext < line_lim);
    accept   = in_frame && bus.LINE_VALID && in_cols && in_lines &&
               (!decim_reg || (!rc[0] && !rl[0]));
  end

  // Window shadow registers, captured only as a frame begins
  always_ff @(posedge PIXCLK) begin
    if (!RESET_N) begin
      x0_reg    <= '0;
      y0_reg    <= '0;
      w_reg     <= '0;
      h_reg     <= '0;
      decim_reg <= 1'b0;
    end else if (frame_begin) begin
      x0_reg    <= bus.WIN_X0;
      y0_reg    <= bus.WIN_Y0;
      w_reg     <= bus.WIN_W;
      h_reg     <= bus.WIN_H;
      decim_reg <= bus.DECIM;
    end
  end

  // Raw column/line counters and line-length integrity tracking
  always_ff @(posedge PIXCLK) begin
    if (!RESET_N || frame_begin) begin
      raw_col_reg    <= '0;
      raw_line_reg   <= '0;
      lv_prev_reg    <= 1'b0;
      have_len_reg   <= 1'b0;
      first_len_reg  <= '0;
      line_error_reg <= 1'b0;
    end else if (in_frame) begin
      lv_prev_reg <= bus.LINE_VALID;
      if (bus.LINE_VALID)
        raw_col_reg <= (&raw_col_reg) ? raw_col_reg : raw_col_reg + RAW_COL_BITS'(1);
      else
        raw_col_reg <= '0;
      if (line_end) begin
        raw_line_reg <= (&raw_line_reg) ? raw_line_reg : raw_line_reg + RAW_LINE_BITS'(1);
        if (!have_len_reg) begin
          first_len_reg <= raw_col_reg;
          have_len_reg  <= 1'b1;
        end else if (raw_col_reg != first_len_reg) begin
          line_error_reg <= 1'b1;
        end
      end
    end else begin
      lv_prev_reg <= 1'b0;
    end
  end

  // Frame markers and completed-frame counter
  always_ff @(posedge PIXCLK) begin
    if (!RESET_N) begin
      frame_start_reg <= 1'b0;
      frame_end_reg   <= 1'b0;
      frame_count_reg <= '0;
    end else begin
      frame_start_reg <= frame_begin;
      frame_end_reg   <= frame_finish;
      if (frame_finish) frame_count_reg <= frame_count_reg + FCNT_BITS'(1);
    end
  end

  // Output pixel register; data and coordinates hold when nothing is accepted
  always_ff @(posedge PIXCLK) begin
    if (!RESET_N) begin
      pixel_valid_reg <= 1'b0;
      data_reg        <= '0;
      column_reg      <= '0;
      line_reg        <= '0;
    end else begin
      pixel_valid_reg <= accept;
      if (accept) begin
        data_reg   <= bus.DATA_IN;
        column_reg <= COL_BITS'(decim_reg ? (rc >> 1) : rc);
        line_reg   <= LINE_BITS'(decim_reg ? (rl >> 1) : rl);
      end
    end
  end

  assign bus.DATA_OUT       = data_reg;
  assign bus.CURRENT_COLUMN = column_reg;
  assign bus.CURRENT_LINE   = line_reg;
  assign bus.PIXEL_VALID    = pixel_valid_reg;
  assign bus.FRAME_START    = frame_start_reg;
  assign bus.FRAME_END      = frame_end_reg;
  assign bus.FRAME_COUNT    = frame_count_reg;
  assign bus.LINE_ERROR     = line_error_reg;
endmodule

// File: tb/tb_camera_window_capture.sv
// Bench for camera_window_capture: directed frames from the test plan followed
// by randomized frames, checked cycle by cycle against a frame-level model
// that works from the raw pixel coordinates the bench itself drives.
module tb_camera_window_capture;
  localparam int DW  = 10;
  localparam int RCB = 10;
  localparam int RLB = 9;
  localparam int CB  = 2;
  localparam int LB  = 2;
  localparam int FB  = 8;

  logic PIXCLK  = 1'b0;
  logic RESET_N = 1'b0;

  camera_window_capture_if #(.DATA_WIDTH(DW), .RAW_COL_BITS(RCB), .RAW_LINE_BITS(RLB),
                             .COL_BITS(CB), .LINE_BITS(LB), .FCNT_BITS(FB)) bus ();

  camera_window_capture #(.DATA_WIDTH(DW), .RAW_COL_BITS(RCB), .RAW_LINE_BITS(RLB),
                          .COL_BITS(CB), .LINE_BITS(LB), .FCNT_BITS(FB)) dut (
    .PIXCLK (PIXCLK),
    .RESET_N(RESET_N),
    .bus    (bus)
  );

  always #5 PIXCLK = ~PIXCLK;

  int vectors = 0;
  int miscompares = 0;

  // Expected output values after the next edge
  bit e_fs, e_fe, e_pv, e_err;
  int e_data, e_col, e_line, e_cnt;

  // Model view of the frame in progress
  int m_x0, m_y0, m_w, m_h;
  bit m_dec;
  bit dead;
  bit have_first;
  int first_len;
  int pix[8][16];
  int len[8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit fv, input bit lv, input int d);
    bus.FRAME_VALID = fv;
    bus.LINE_VALID  = lv;
    bus.DATA_IN     = DW'(d);
    @(posedge PIXCLK);
    #1;
    check("frame_start", 32'(bus.FRAME_START), 32'(e_fs));
    check("frame_end",   32'(bus.FRAME_END),   32'(e_fe));
    check("pixel_valid", 32'(bus.PIXEL_VALID), 32'(e_pv));
    check("data_out",    32'(bus.DATA_OUT),    32'(e_data));
    check("column",      32'(bus.CURRENT_COLUMN), 32'(e_col));
    check("line",        32'(bus.CURRENT_LINE),   32'(e_line));
    check("line_error",  32'(bus.LINE_ERROR),  32'(e_err));
    check("frame_count", 32'(bus.FRAME_COUNT), 32'(e_cnt));
  endtask

  task automatic set_cfg(input int x0, input int y0, input int w, input int h, input bit dec);
    bus.WIN_X0 = RCB'(x0);
    bus.WIN_Y0 = RLB'(y0);
    bus.WIN_W  = RCB'(w);
    bus.WIN_H  = RLB'(h);
    bus.DECIM  = dec;
  endtask

  // mode 0: 10*(line+1)+col+1, mode 1: 10*line+col, otherwise random
  task automatic fill(input int mode, input int length);
    for (int l = 0; l < 8; l++) begin
      len[l] = length;
      for (int c = 0; c < 16; c++)
        pix[l][c] = (mode == 0) ? 10 * (l + 1) + c + 1 :
                    (mode == 1) ? 10 * l + c : int'($urandom_range(0, 1023));
    end
  endtask

  // Drive one raw pixel at (c,l) and predict the windowed output
  task automatic drive_pixel(input int c, input int l);
    int rc, rl;
    rc = c - m_x0;
    rl = l - m_y0;
    e_fs = 0;
    e_fe = 0;
    e_pv = 0;
    if (!dead && rc >= 0 && rc < m_w && rl >= 0 && rl < m_h &&
        (!m_dec || (rc % 2 == 0 && rl % 2 == 0))) begin
      e_pv   = 1;
      e_data = pix[l][c];
      e_col  = (m_dec ? rc / 2 : rc) % 4;
      e_line = (m_dec ? rl / 2 : rl) % 4;
    end
    step(1'b1, 1'b1, pix[l][c]);
  endtask

  // One frame: FV rise, porch, lines separated by two blanking cycles, FV fall
  task automatic send_frame(input int nlines, input bit trunc, input int abort_line,
                            input int gap, input bit scramble);
    dead  = 0;
    m_x0  = int'(bus.WIN_X0);
    m_y0  = int'(bus.WIN_Y0);
    m_w   = int'(bus.WIN_W);
    m_h   = int'(bus.WIN_H);
    m_dec = bus.DECIM;
    have_first = 0;
    e_fs = 1; e_fe = 0; e_pv = 0; e_err = 0;
    step(1'b1, 1'b0, 0);
    e_fs = 0;
    step(1'b1, 1'b0, 0);
    for (int l = 0; l < nlines; l++) begin
      for (int c = 0; c < len[l]; c++) begin
        if (l == abort_line && c == 1) begin
          RESET_N = 1'b0;
          dead = 1;
          e_fs = 0; e_fe = 0; e_pv = 0; e_err = 0;
          e_data = 0; e_col = 0; e_line = 0; e_cnt = 0;
          step(1'b1, 1'b1, pix[l][c]);
          RESET_N = 1'b1;
        end else begin
          drive_pixel(c, l);
        end
      end
      if (scramble && l == 0) begin
        bus.WIN_X0 = RCB'($urandom_range(0, 7));
        bus.WIN_W  = RCB'($urandom_range(0, 7));
        bus.DECIM  = ~bus.DECIM;
      end
      if (trunc && l == nlines - 1) break;
      e_pv = 0;
      if (!dead) begin
        if (!have_first) begin
          have_first = 1;
          first_len  = len[l];
        end else if (len[l] != first_len) begin
          e_err = 1;
        end
      end
      step(1'b1, 1'b0, 0);
      step(1'b1, 1'b0, 0);
    end
    e_pv = 0;
    if (!dead) begin
      e_fe  = 1;
      e_cnt = (e_cnt + 1) % 256;
    end
    step(1'b0, 1'b0, 0);
    e_fe = 0;
    // Between frames LINE_VALID is toggled freely; it must be ignored
    for (int g = 0; g < gap; g++)
      step(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 1023)));
  endtask

  initial begin
    bus.FRAME_VALID = 1'b1;
    bus.LINE_VALID  = 1'b1;
    bus.DATA_IN     = '0;
    set_cfg(0, 0, 2, 3, 0);
    e_fs = 0; e_fe = 0; e_pv = 0; e_err = 0;
    e_data = 0; e_col = 0; e_line = 0; e_cnt = 0;
    dead = 1;

    // Startup inside an ongoing frame: nothing until FV falls and rises again
    RESET_N = 1'b0;
    repeat (3) step(1'b1, 1'b1, 5);
    RESET_N = 1'b1;
    repeat (20) step(1'b1, 1'b1, int'($urandom_range(0, 1023)));
    step(1'b0, 1'b0, 0);

    // Full 2x3 window
    fill(0, 2);
    send_frame(3, 0, -1, 1, 0);

    // Crop 2x2 at (1,1) of a 4x4 frame
    set_cfg(1, 1, 2, 2, 0);
    fill(1, 4);
    send_frame(4, 0, -1, 2, 0);

    // 2x2 decimation of a 4x4 window
    set_cfg(0, 0, 4, 4, 1);
    send_frame(4, 0, -1, 1, 0);

    // Config changed mid-frame must not affect the running frame
    set_cfg(1, 1, 2, 2, 0);
    send_frame(4, 0, -1, 1, 1);

    // Line lengths 4,4,3 set LINE_ERROR; FV rise right after FE clears it
    set_cfg(0, 0, 8, 8, 0);
    fill(1, 4);
    len[2] = 3;
    send_frame(3, 0, -1, 0, 0);

    // Frame ending mid-line leaves LINE_ERROR clear
    fill(1, 4);
    len[1] = 2;
    send_frame(2, 1, -1, 1, 0);

    // Window entirely outside the sensor area
    set_cfg(100, 0, 5, 4, 0);
    send_frame(3, 0, -1, 1, 0);

    // Reset during line 2, then a fresh frame restarts the counter from 0
    set_cfg(0, 0, 4, 4, 0);
    fill(1, 4);
    send_frame(4, 0, 1, 1, 0);
    send_frame(4, 0, -1, 1, 0);

    // Randomized windows, frame shapes and data
    for (int f = 0; f < 40; f++) begin
      int nl, base;
      bit tr;
      set_cfg(int'($urandom_range(0, 5)), int'($urandom_range(0, 4)),
              int'($urandom_range(0, 6)), int'($urandom_range(0, 5)),
              1'($urandom_range(0, 1)));
      nl   = int'($urandom_range(1, 6));
      base = int'($urandom_range(1, 8));
      fill(2, base);
      for (int l = 0; l < 8; l++)
        if ($urandom_range(0, 4) == 0) len[l] = int'($urandom_range(1, 8));
      tr = ($urandom_range(0, 3) == 0);
      send_frame(nl, tr, -1, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
